// File: rtl/hub75_pkg.sv
// ---------------------------------------------------------------------------
// hub75_pkg
// Shared constants for the Hub75 APB CSR block. It holds:
//   - the register byte offsets inside the register region
//   - the STATUS and IRQ_EN bit positions
//   - the frame counter width
//   - the decoded register-select enum
//   - a byte-strobe merge helper used by every byte-writable register
// No ports; imported by apb_hub75_csr and hub75_bank_ctrl.
// ---------------------------------------------------------------------------
package hub75_pkg;

  // Register byte offsets within the register region. The decode compares
  // the low 8 offset bits and separately requires all higher bits to be zero.
  localparam logic [7:0] OFF_ID        = 8'h00;
  localparam logic [7:0] OFF_STATUS    = 8'h04;
  localparam logic [7:0] OFF_IRQ_EN    = 8'h08;
  localparam logic [7:0] OFF_BANK_CTRL = 8'h0C;
  localparam logic [7:0] OFF_PPROW     = 8'h10;
  localparam logic [7:0] OFF_CTRL_BASE = 8'h40;

  // STATUS bit positions.
  localparam int ST_FRAME_DONE   = 0;
  localparam int ST_SWAP_PENDING = 1;
  localparam int ST_ACTIVE_BANK  = 2;
  localparam int ST_SWAP_DONE    = 3;
  localparam int ST_FCOUNT_LSB   = 8;

  // IRQ_EN bit positions.
  localparam int IRQ_EN_FRAME = 0;
  localparam int IRQ_EN_SWAP  = 1;

  // Width of the frame counter; it wraps naturally at 2**FRAME_CNT_W.
  localparam int FRAME_CNT_W = 8;

  // Which register the current APB address points at.
  typedef enum logic [2:0] {
    REG_ID,
    REG_STATUS,
    REG_IRQ_EN,
    REG_BANK_CTRL,
    REG_PPROW,
    REG_CTRL,
    REG_BAD
  } reg_sel_e;

  // Replace each byte of oldVal whose strobe bit is set with the matching
  // byte of newVal.
  function automatic logic [31:0] applyStrobe(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = newVal[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hub75_bank_ctrl.sv
// ---------------------------------------------------------------------------
// hub75_bank_ctrl
// Bank-swap handshake, sticky status bits, frame counter and interrupt.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   frame_done_i          one-cycle end-of-frame pulse from the scan engine
//   swap_req_i            decoded BANK_CTRL write requesting a swap
//   w1c_frame_i           decoded W1C of STATUS.frame_done
//   w1c_swap_i            decoded W1C of STATUS.swap_done
//   irq_en_we_i           IRQ_EN write strobe
//   irq_en_wdata_i [1:0]  new IRQ_EN value
//   swap_pending_o, active_bank_o, st_frame_o, st_swap_o  state outputs
//   frame_count_o         frame counter
//   irq_en_o [1:0]        current IRQ_EN value
//   irq_o                 registered level interrupt
// ---------------------------------------------------------------------------
module hub75_bank_ctrl
  import hub75_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   frame_done_i,
  input  logic                   swap_req_i,
  input  logic                   w1c_frame_i,
  input  logic                   w1c_swap_i,
  input  logic                   irq_en_we_i,
  input  logic [1:0]             irq_en_wdata_i,
  output logic                   swap_pending_o,
  output logic                   active_bank_o,
  output logic                   st_frame_o,
  output logic                   st_swap_o,
  output logic [FRAME_CNT_W-1:0] frame_count_o,
  output logic [1:0]             irq_en_o,
  output logic                   irq_o
);

  logic                   pending_q,  pending_d;
  logic                   bank_q,     bank_d;
  logic                   stFrame_q,  stFrame_d;
  logic                   stSwap_q,   stSwap_d;
  logic [FRAME_CNT_W-1:0] count_q,    count_d;
  logic [1:0]             irqEn_q,    irqEn_d;
  logic                   irq_q,      irq_d;

  // Next-state logic. Software clears of the sticky bits are applied first
  // so a hardware set in the same cycle overrides them. A swap request that
  // arrives while a swap is being committed this frame is absorbed by that
  // commit; one that arrives with nothing pending waits for the next frame.
  // irq is computed from the next-state values so it lines up with STATUS.
  always_comb begin
    pending_d = pending_q;
    bank_d    = bank_q;
    stFrame_d = stFrame_q;
    stSwap_d  = stSwap_q;
    count_d   = count_q;
    irqEn_d   = irqEn_q;

    if (irq_en_we_i) irqEn_d = irq_en_wdata_i;
    if (w1c_frame_i) stFrame_d = 1'b0;
    if (w1c_swap_i)  stSwap_d  = 1'b0;

    if (frame_done_i) begin
      stFrame_d = 1'b1;
      count_d   = count_q + 1'b1;
      if (pending_q) begin
        bank_d    = ~bank_q;
        pending_d = 1'b0;
        stSwap_d  = 1'b1;
      end
    end

    if (swap_req_i && !(frame_done_i && pending_q)) pending_d = 1'b1;

    irq_d = (stFrame_d & irqEn_d[IRQ_EN_FRAME]) |
            (stSwap_d  & irqEn_d[IRQ_EN_SWAP]);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      bank_q    <= 1'b0;
      stFrame_q <= 1'b0;
      stSwap_q  <= 1'b0;
      count_q   <= '0;
      irqEn_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      bank_q    <= bank_d;
      stFrame_q <= stFrame_d;
      stSwap_q  <= stSwap_d;
      count_q   <= count_d;
      irqEn_q   <= irqEn_d;
      irq_q     <= irq_d;
    end
  end

  assign swap_pending_o = pending_q;
  assign active_bank_o  = bank_q;
  assign st_frame_o     = stFrame_q;
  assign st_swap_o      = stSwap_q;
  assign frame_count_o  = count_q;
  assign irq_en_o       = irqEn_q;
  assign irq_o          = irq_q;

endmodule

// File: rtl/apb_hub75_csr.sv
// ---------------------------------------------------------------------------
// apb_hub75_csr
// APB4 control/status registers and double-buffered frame-buffer write port
// for the Hub75 panel driver.
// Ports:
//   pclk, preset                  clock, synchronous active-high reset
//   psel/penable/pwrite/paddr/pwdata/pstrb   APB4 request
//   prdata/pready/pslverr         APB4 response (zero wait states)
//   frame_done                    end-of-frame pulse from the scan engine
//   control                       NUM_CTRL packed 32-bit control registers
//   pixels_per_row                row length register
//   mem_wr/mem_be/mem_data/mem_waddr/mem_bank  frame-buffer write port
//   active_bank                   bank currently shown by the scan engine
//   irq                           level interrupt
// paddr[ADDR_W-1] selects the register region (1) or frame buffer (0).
// ADDR_W must be at least 9 so the register offset covers 8 bits.
// ---------------------------------------------------------------------------
module apb_hub75_csr
  import hub75_pkg::*;
#(
  parameter int          ADDR_W          = 18,
  parameter int          NUM_CTRL        = 4,
  parameter int          PPR_W           = 9,
  parameter logic [31:0] DEFAULT_CONTROL = 32'h0000_0001,
  parameter int          DEFAULT_PPR     = 64,
  parameter logic [31:0] BLOCK_ID        = 32'hDEAD_BEEF
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [31:0]           pwdata,
  input  logic [3:0]            pstrb,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  frame_done,
  output logic [NUM_CTRL*32-1:0] control,
  output logic [PPR_W-1:0]      pixels_per_row,
  output logic                  mem_wr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_data,
  output logic [ADDR_W-4:0]     mem_waddr,
  output logic                  mem_bank,
  output logic                  active_bank,
  output logic                  irq
);

  localparam logic [4:0] NUM_CTRL_L = 5'(NUM_CTRL);

  // Decode signals.
  logic              isReg;
  logic              setupPhase;
  logic              wrAccess;
  logic              regWrite;
  logic              fbWrite;
  logic [ADDR_W-2:0] regOff;
  logic [7:0]        offLo;
  logic              offHiZero;
  logic [3:0]        ctrlIdx;
  reg_sel_e          regSel;
  logic [31:0]       pprMerged;
  logic [PPR_W-1:0]  pprNew;
  logic              regErr;
  logic [31:0]       ctrlRd;
  logic [31:0]       statusWord;
  logic [31:0]       rdMux;

  // Register state.
  logic [31:0]       rdData_q;
  logic              slvErr_q;
  logic [31:0]       ctrl_q [NUM_CTRL];
  logic [31:0]       ctrl_d [NUM_CTRL];
  logic [PPR_W-1:0]  ppr_q, ppr_d;
  logic              memWr_q;
  logic [3:0]        memBe_q;
  logic [31:0]       memData_q;
  logic [ADDR_W-4:0] memWaddr_q;
  logic              memBank_q;

  // Bank controller interface.
  logic                   swapReq;
  logic                   w1cFrame;
  logic                   w1cSwap;
  logic                   irqEnWe;
  logic                   swapPending;
  logic                   activeBank;
  logic                   stFrame;
  logic                   stSwap;
  logic [FRAME_CNT_W-1:0] frameCount;
  logic [1:0]             irqEn;
  logic                   irqLevel;

  assign isReg      = paddr[ADDR_W-1];
  assign setupPhase = psel & ~penable;
  assign wrAccess   = psel & penable & pwrite;
  assign regWrite   = wrAccess & isReg;
  assign fbWrite    = wrAccess & ~isReg;

  // Address decode. Any offset that is not exactly one of the known
  // word-aligned registers resolves to REG_BAD.
  always_comb begin
    regOff    = paddr[ADDR_W-2:0];
    offLo     = regOff[7:0];
    offHiZero = ((regOff >> 8) == '0);
    ctrlIdx   = offLo[5:2];
    regSel    = REG_BAD;
    if (offHiZero) begin
      if (offLo == OFF_ID)             regSel = REG_ID;
      else if (offLo == OFF_STATUS)    regSel = REG_STATUS;
      else if (offLo == OFF_IRQ_EN)    regSel = REG_IRQ_EN;
      else if (offLo == OFF_BANK_CTRL) regSel = REG_BANK_CTRL;
      else if (offLo == OFF_PPROW)     regSel = REG_PPROW;
      else if ((offLo[7:6] == OFF_CTRL_BASE[7:6]) && (offLo[1:0] == 2'b00) &&
               ({1'b0, ctrlIdx} < NUM_CTRL_L))
        regSel = REG_CTRL;
    end
  end

  // Value PPROW would take if this write landed; a zero result is refused
  // both when the error is decoded in setup and when the write commits.
  always_comb begin
    pprMerged = applyStrobe(32'(ppr_q), pwdata, {2'b00, pstrb[1:0]});
    pprNew    = pprMerged[PPR_W-1:0];
    regErr    = (regSel == REG_BAD) ||
                (pwrite && (regSel == REG_PPROW) && (pprNew == '0));
  end

  // Read data mux, including the STATUS word assembled from the bank
  // controller state.
  always_comb begin
    ctrlRd = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (ctrlIdx == 4'(i)) ctrlRd = ctrl_q[i];
    end

    statusWord                                 = '0;
    statusWord[ST_FRAME_DONE]                  = stFrame;
    statusWord[ST_SWAP_PENDING]                = swapPending;
    statusWord[ST_ACTIVE_BANK]                 = activeBank;
    statusWord[ST_SWAP_DONE]                   = stSwap;
    statusWord[ST_FCOUNT_LSB +: FRAME_CNT_W]   = frameCount;

    case (regSel)
      REG_ID:        rdMux = BLOCK_ID;
      REG_STATUS:    rdMux = statusWord;
      REG_IRQ_EN:    rdMux = {30'b0, irqEn};
      REG_BANK_CTRL: rdMux = {31'b0, swapPending};
      REG_PPROW:     rdMux = 32'(ppr_q);
      REG_CTRL:      rdMux = ctrlRd;
      default:       rdMux = '0;
    endcase
  end

  // APB response is captured in the setup phase and held through the access
  // phase; it drops back to zero once the bus goes idle.
  always_ff @(posedge pclk) begin
    if (preset) begin
      rdData_q <= '0;
      slvErr_q <= 1'b0;
    end else if (setupPhase) begin
      rdData_q <= (isReg && !pwrite) ? rdMux : '0;
      slvErr_q <= isReg & regErr;
    end else if (!psel) begin
      rdData_q <= '0;
      slvErr_q <= 1'b0;
    end
  end

  // Register file next state: PPROW and the CONTROL bank commit at the end
  // of the access phase with per-byte strobes.
  always_comb begin
    ppr_d  = ppr_q;
    ctrl_d = ctrl_q;
    if (regWrite) begin
      if ((regSel == REG_PPROW) && (pprNew != '0)) ppr_d = pprNew;
      if (regSel == REG_CTRL) begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (ctrlIdx == 4'(i)) ctrl_d[i] = applyStrobe(ctrl_q[i], pwdata, pstrb);
        end
      end
    end
  end

  // Register file state.
  always_ff @(posedge pclk) begin
    if (preset) begin
      ppr_q <= PPR_W'(DEFAULT_PPR);
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= DEFAULT_CONTROL;
    end else begin
      ppr_q  <= ppr_d;
      ctrl_q <= ctrl_d;
    end
  end

  // Frame-buffer write stage: one registered pulse per non-empty write.
  // mem_bank follows the back bank one cycle late, so the bank seen with a
  // pulse is the one that was the back bank at the end of that access phase.
  always_ff @(posedge pclk) begin
    if (preset) begin
      memWr_q    <= 1'b0;
      memBe_q    <= '0;
      memData_q  <= '0;
      memWaddr_q <= '0;
      memBank_q  <= 1'b1;
    end else begin
      memWr_q   <= 1'b0;
      memBank_q <= ~activeBank;
      if (fbWrite && (pstrb != 4'b0000)) begin
        memWr_q    <= 1'b1;
        memBe_q    <= pstrb;
        memData_q  <= pwdata;
        memWaddr_q <= paddr[ADDR_W-2:2];
      end
    end
  end

  // Write strobes for the bank controller; all require byte lane 0.
  assign swapReq  = regWrite && (regSel == REG_BANK_CTRL) && pstrb[0] && pwdata[0];
  assign w1cFrame = regWrite && (regSel == REG_STATUS) && pstrb[0] && pwdata[ST_FRAME_DONE];
  assign w1cSwap  = regWrite && (regSel == REG_STATUS) && pstrb[0] && pwdata[ST_SWAP_DONE];
  assign irqEnWe  = regWrite && (regSel == REG_IRQ_EN) && pstrb[0];

  hub75_bank_ctrl uBankCtrl (
    .clk_i          (pclk),
    .rst_i          (preset),
    .frame_done_i   (frame_done),
    .swap_req_i     (swapReq),
    .w1c_frame_i    (w1cFrame),
    .w1c_swap_i     (w1cSwap),
    .irq_en_we_i    (irqEnWe),
    .irq_en_wdata_i (pwdata[1:0]),
    .swap_pending_o (swapPending),
    .active_bank_o  (activeBank),
    .st_frame_o     (stFrame),
    .st_swap_o      (stSwap),
    .frame_count_o  (frameCount),
    .irq_en_o       (irqEn),
    .irq_o          (irqLevel)
  );

  for (genvar g = 0; g < NUM_CTRL; g++) begin : gCtrlOut
    assign control[32*g +: 32] = ctrl_q[g];
  end

  assign prdata         = rdData_q;
  assign pready         = 1'b1;
  assign pslverr        = slvErr_q;
  assign pixels_per_row = ppr_q;
  assign mem_wr         = memWr_q;
  assign mem_be         = memBe_q;
  assign mem_data       = memData_q;
  assign mem_waddr      = memWaddr_q;
  assign mem_bank       = memBank_q;
  assign active_bank    = activeBank;
  assign irq            = irqLevel;

endmodule

// File: tb/tb_apb_hub75_csr.sv
// ---------------------------------------------------------------------------
// tb_apb_hub75_csr
// Directed bench for apb_hub75_csr with default parameters. APB transfers
// start one time unit after a rising edge; outputs are sampled at that same
// offset, away from the clock edge.
// ---------------------------------------------------------------------------
module tb_apb_hub75_csr;

  localparam logic [17:0] REG = 18'h20000;

  logic         pclk = 1'b0;
  logic         preset;
  logic         psel, penable, pwrite;
  logic [17:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata;
  logic         pready, pslverr;
  logic         frame_done;
  logic [127:0] control;
  logic [8:0]   pixels_per_row;
  logic         mem_wr;
  logic [3:0]   mem_be;
  logic [31:0]  mem_data;
  logic [14:0]  mem_waddr;
  logic         mem_bank, active_bank, irq;

  int vectors     = 0;
  int miscompares = 0;

  // Captured frame-buffer write pulses, one entry per cycle mem_wr is high.
  logic [14:0] wrAddrQ [$];
  logic        lastBank;
  logic [3:0]  lastBe;
  logic [31:0] lastData;

  apb_hub75_csr dut (
    .pclk           (pclk),
    .preset         (preset),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .paddr          (paddr),
    .pwdata         (pwdata),
    .pstrb          (pstrb),
    .prdata         (prdata),
    .pready         (pready),
    .pslverr        (pslverr),
    .frame_done     (frame_done),
    .control        (control),
    .pixels_per_row (pixels_per_row),
    .mem_wr         (mem_wr),
    .mem_be         (mem_be),
    .mem_data       (mem_data),
    .mem_waddr      (mem_waddr),
    .mem_bank       (mem_bank),
    .active_bank    (active_bank),
    .irq            (irq)
  );

  // 10-unit clock.
  always #5 pclk = ~pclk;

  // Log every cycle in which the frame-buffer write strobe is high.
  always @(negedge pclk) begin
    if (mem_wr === 1'b1) begin
      wrAddrQ.push_back(mem_waddr);
      lastBank = mem_bank;
      lastBe   = mem_be;
      lastData = mem_data;
    end
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One APB transfer starting in the current cycle. frame_done can be
  // pulsed in the access phase so it coincides with the write commit.
  task automatic applyStimulus(input logic wr, input logic [17:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input logic fdInAccess,
                               output logic [31:0] rdata, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = data; pstrb = strb;
    @(posedge pclk); #1;
    penable = 1'b1; frame_done = fdInAccess;
    rdata = prdata; err = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; frame_done = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic pulseFrame();
    frame_done = 1'b1;
    @(posedge pclk); #1;
    frame_done = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; frame_done = 1'b0;
    tick(3);
    preset = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_prdata", prdata, 32'h0);
    checkOutput("rst_pslverr", {31'b0, pslverr}, 32'h0);
    checkOutput("rst_pready", {31'b0, pready}, 32'h1);
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);
    checkOutput("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    checkOutput("rst_active_bank", {31'b0, active_bank}, 32'h0);
    checkOutput("rst_mem_bank", {31'b0, mem_bank}, 32'h1);
    checkOutput("rst_ctrl0", control[31:0], 32'h1);
    checkOutput("rst_ctrl3", control[127:96], 32'h1);
    checkOutput("rst_ppr", {23'b0, pixels_per_row}, 32'd64);

    $display("[TB] ID / CONTROL_0 / PPROW reads");
    applyStimulus(1'b0, REG | 18'h00, '0, 4'h0, 1'b0, rd, err);
    checkOutput("id_read", rd, 32'hDEADBEEF);
    checkOutput("id_err", {31'b0, err}, 32'h0);
    applyStimulus(1'b0, REG | 18'h40, '0, 4'h0, 1'b0, rd, err);
    checkOutput("ctrl0_read", rd, 32'h1);
    applyStimulus(1'b0, REG | 18'h10, '0, 4'h0, 1'b0, rd, err);
    checkOutput("ppr_read", rd, 32'd64);
    checkOutput("ppr_read_err", {31'b0, err}, 32'h0);

    $display("[TB] byte-strobed CONTROL_1, PPROW zero reject, bad offset");
    applyStimulus(1'b1, REG | 18'h44, 32'hAABBCCDD, 4'b0101, 1'b0, rd, err);
    checkOutput("ctrl1_wr_err", {31'b0, err}, 32'h0);
    checkOutput("ctrl1_port", control[63:32], 32'h00BB00DD);
    applyStimulus(1'b0, REG | 18'h44, '0, 4'h0, 1'b0, rd, err);
    checkOutput("ctrl1_read", rd, 32'h00BB00DD);
    applyStimulus(1'b1, REG | 18'h10, 32'h0, 4'b0011, 1'b0, rd, err);
    checkOutput("ppr_zero_err", {31'b0, err}, 32'h1);
    checkOutput("ppr_zero_port", {23'b0, pixels_per_row}, 32'd64);
    applyStimulus(1'b0, REG | 18'h10, '0, 4'h0, 1'b0, rd, err);
    checkOutput("ppr_zero_read", rd, 32'd64);
    applyStimulus(1'b1, REG | 18'h10, 32'h0000_0120, 4'b0011, 1'b0, rd, err);
    checkOutput("ppr_wr_err", {31'b0, err}, 32'h0);
    checkOutput("ppr_wr_port", {23'b0, pixels_per_row}, 32'h120);
    applyStimulus(1'b0, REG | 18'h20, '0, 4'h0, 1'b0, rd, err);
    checkOutput("bad_off_read", rd, 32'h0);
    checkOutput("bad_off_err", {31'b0, err}, 32'h1);
    applyStimulus(1'b1, REG | 18'h50, 32'h1234_5678, 4'hF, 1'b0, rd, err);
    checkOutput("ctrl4_absent_err", {31'b0, err}, 32'h1);

    $display("[TB] frame-buffer writes");
    applyStimulus(1'b1, 18'h00004, 32'h1111_1111, 4'hF, 1'b0, rd, err);
    applyStimulus(1'b1, 18'h00008, 32'h2222_2222, 4'hF, 1'b0, rd, err);
    applyStimulus(1'b1, 18'h0000C, 32'h3333_3333, 4'b0110, 1'b0, rd, err);
    applyStimulus(1'b1, 18'h00010, 32'h4444_4444, 4'b0000, 1'b0, rd, err);
    tick(2);
    checkOutput("fb_pulses", wrAddrQ.size(), 32'd3);
    checkOutput("fb_waddr0", {17'b0, wrAddrQ[0]}, 32'd1);
    checkOutput("fb_waddr1", {17'b0, wrAddrQ[1]}, 32'd2);
    checkOutput("fb_waddr2", {17'b0, wrAddrQ[2]}, 32'd3);
    checkOutput("fb_bank", {31'b0, lastBank}, 32'h1);
    checkOutput("fb_be", {28'b0, lastBe}, 32'h6);
    checkOutput("fb_data", lastData, 32'h3333_3333);
    applyStimulus(1'b0, 18'h00010, '0, 4'h0, 1'b0, rd, err);
    checkOutput("fb_read", rd, 32'h0);
    checkOutput("fb_read_err", {31'b0, err}, 32'h0);

    $display("[TB] bank swap");
    applyStimulus(1'b1, REG | 18'h0C, 32'h1, 4'h1, 1'b0, rd, err);
    applyStimulus(1'b0, REG | 18'h0C, '0, 4'h0, 1'b0, rd, err);
    checkOutput("bank_ctrl_read", rd, 32'h1);
    applyStimulus(1'b0, REG | 18'h04, '0, 4'h0, 1'b0, rd, err);
    checkOutput("status_pending", rd, 32'h2);
    checkOutput("bank_before_frame", {31'b0, active_bank}, 32'h0);
    pulseFrame();
    checkOutput("bank_after_frame", {31'b0, active_bank}, 32'h1);
    tick(1);
    checkOutput("mem_bank_after_swap", {31'b0, mem_bank}, 32'h0);
    applyStimulus(1'b1, REG | 18'h04, 32'h1, 4'h1, 1'b0, rd, err);
    applyStimulus(1'b0, REG | 18'h04, '0, 4'h0, 1'b0, rd, err);
    checkOutput("status_after_swap", rd, 32'h0000_010C);

    $display("[TB] swap write coinciding with frame_done");
    applyStimulus(1'b1, REG | 18'h0C, 32'h1, 4'h1, 1'b1, rd, err);
    checkOutput("coincide_no_toggle", {31'b0, active_bank}, 32'h1);
    applyStimulus(1'b0, REG | 18'h04, '0, 4'h0, 1'b0, rd, err);
    checkOutput("coincide_status", rd, 32'h0000_020F);
    pulseFrame();
    checkOutput("coincide_next_toggle", {31'b0, active_bank}, 32'h0);
    applyStimulus(1'b0, REG | 18'h04, '0, 4'h0, 1'b0, rd, err);
    checkOutput("coincide_status2", rd, 32'h0000_0309);

    $display("[TB] interrupt");
    applyStimulus(1'b1, REG | 18'h04, 32'h9, 4'h1, 1'b0, rd, err);
    applyStimulus(1'b1, REG | 18'h08, 32'h1, 4'h1, 1'b0, rd, err);
    checkOutput("irq_idle", {31'b0, irq}, 32'h0);
    applyStimulus(1'b0, REG | 18'h08, '0, 4'h0, 1'b0, rd, err);
    checkOutput("irq_en_read", rd, 32'h1);
    pulseFrame();
    checkOutput("irq_set", {31'b0, irq}, 32'h1);
    applyStimulus(1'b1, REG | 18'h04, 32'h1, 4'h1, 1'b1, rd, err);
    checkOutput("irq_set_wins", {31'b0, irq}, 32'h1);
    applyStimulus(1'b0, REG | 18'h04, '0, 4'h0, 1'b0, rd, err);
    checkOutput("status_set_wins", rd, 32'h0000_0501);
    applyStimulus(1'b1, REG | 18'h04, 32'h1, 4'h1, 1'b0, rd, err);
    checkOutput("irq_cleared", {31'b0, irq}, 32'h0);

    $display("[TB] frame counter wrap");
    repeat (250) pulseFrame();
    applyStimulus(1'b0, REG | 18'h04, '0, 4'h0, 1'b0, rd, err);
    checkOutput("fcount_255", rd, 32'h0000_FF01);
    pulseFrame();
    applyStimulus(1'b0, REG | 18'h04, '0, 4'h0, 1'b0, rd, err);
    checkOutput("fcount_wrap", rd, 32'h0000_0001);
    checkOutput("irq_before_reset", {31'b0, irq}, 32'h1);

    $display("[TB] reset during access phase");
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 18'h00040; pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    checkOutput("mid_rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    checkOutput("mid_rst_irq", {31'b0, irq}, 32'h0);
    checkOutput("mid_rst_ctrl1", control[63:32], 32'h1);
    checkOutput("mid_rst_ppr", {23'b0, pixels_per_row}, 32'd64);
    checkOutput("mid_rst_mem_be", {28'b0, mem_be}, 32'h0);
    checkOutput("mid_rst_mem_waddr", {17'b0, mem_waddr}, 32'h0);
    checkOutput("mid_rst_prdata", prdata, 32'h0);
    checkOutput("mid_rst_pslverr", {31'b0, pslverr}, 32'h0);
    preset = 1'b0;
    tick(2);
    checkOutput("mid_rst_no_pulse", wrAddrQ.size(), 32'd3);
    applyStimulus(1'b0, REG | 18'h04, '0, 4'h0, 1'b0, rd, err);
    checkOutput("mid_rst_status", rd, 32'h0);
    applyStimulus(1'b0, REG | 18'h08, '0, 4'h0, 1'b0, rd, err);
    checkOutput("mid_rst_irq_en", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
